// File: rtl/xor_descr_pkg.sv
// ----------------------------------------------------------------------------
// xor_descr_pkg
// Shared definitions for the XOR descrambler and its matching scrambler:
//   POLY_DEFAULT  - Galois feedback taps of the 32-bit keystream LFSR
//   ZERO_SEED_SUB - value loaded instead of an all-zero seed, because an
//                   all-zero LFSR never leaves zero
//   state_e       - sequencing state of the descrambler
//   lfsr_step1    - single Galois step, for reference and reuse
// ----------------------------------------------------------------------------
package xor_descr_pkg;

    localparam int          LFSR_WIDTH    = 32;
    localparam logic [31:0] POLY_DEFAULT  = 32'h04C1_1DB7;
    localparam logic [31:0] ZERO_SEED_SUB = 32'hFFFF_FFFF;

    typedef enum logic {
        UNSEEDED = 1'b0,
        RUN      = 1'b1
    } state_e;

    // One Galois step: shift left, fold the bit shifted out back in through the taps.
    function automatic logic [31:0] lfsr_step1(input logic [31:0] s,
                                               input logic [31:0] poly);
        lfsr_step1 = {s[30:0], 1'b0} ^ (s[31] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/xor_descrambler_lfsr_step32.sv
// ----------------------------------------------------------------------------
// lfsr_step32
// Purely combinational advance of a 32-bit Galois LFSR by 32 steps, i.e. one
// full keystream word. Shared between the scrambler and the descrambler so
// both sides are guaranteed to walk the same sequence.
//
// Parameters:
//   POLY  - Galois feedback taps
// Ports:
//   s_i   in  32  current LFSR state
//   s_o   out 32  state after 32 steps
// ----------------------------------------------------------------------------
module lfsr_step32
    import xor_descr_pkg::*;
#(
    parameter logic [31:0] POLY = POLY_DEFAULT
) (
    input  logic [31:0] s_i,
    output logic [31:0] s_o
);

    always_comb begin
        s_o = s_i;
        for (int i = 0; i < 32; i++) begin
            s_o = lfsr_step1(s_o, POLY);
        end
    end

endmodule

// File: rtl/xor_descrambler.sv
// ----------------------------------------------------------------------------
// xor_descrambler
// Streaming 32-bit additive descrambler. Each accepted word is XORed with the
// current LFSR state (the keystream word) and registered on the output; the
// LFSR then advances by 32 steps. Valid/ready on both sides, one output stage.
//
// Optional feature (compile-time macro XOR_DESCR_BYPASS_EN):
//   adds input port bypass; an accepted word with bypass=1 passes through
//   unchanged and the LFSR is not advanced.
//
// Parameters:
//   WIDTH     - data / LFSR width (only 32 supported)
//   POLY      - Galois feedback taps
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   seed_load  in   1   load LFSR from seed this cycle
//   seed       in   32  seed value (0 is replaced by all-ones)
//   in_valid   in   1   input word present
//   in_ready   out  1   input accepted this cycle
//   in_data    in   32  scrambled word
//   out_valid  out  1   output word present
//   out_ready  in   1   consumer accepts output
//   out_data   out  32  descrambled word
//   locked     out  1   a seed has been loaded since reset
//   bypass     in   1   (XOR_DESCR_BYPASS_EN only) pass word through unchanged
//
// State table
//   state    | meaning
//   UNSEEDED | after reset, no keystream yet; input is never accepted
//   RUN      | seeded; words are accepted and descrambled
// ----------------------------------------------------------------------------
module xor_descrambler
    import xor_descr_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter logic [31:0] POLY  = POLY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             locked
`ifdef XOR_DESCR_BYPASS_EN
    ,
    input  logic             bypass
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] lfsr_adv;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             accept;
    logic             drain;
    logic             pass_through;

    lfsr_step32 #(
        .POLY (POLY)
    ) u_step32 (
        .s_i (lfsr_q),
        .s_o (lfsr_adv)
    );

`ifdef XOR_DESCR_BYPASS_EN
    assign pass_through = bypass;
`else
    assign pass_through = 1'b0;
`endif

    // The output slot frees up either when it is empty or when it drains this
    // cycle, so a full slot can be refilled back-to-back. Seed load blocks
    // accept so a word never sees a half-updated keystream.
    assign in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // accept is never true together with seed_load, so the two LFSR
        // updates below are mutually exclusive.
        if (seed_load) begin
            state_d = RUN;
            lfsr_d  = (seed == '0) ? ZERO_SEED_SUB : seed;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            if (pass_through) begin
                out_data_d = in_data;
            end else begin
                out_data_d = in_data ^ lfsr_q;
                lfsr_d     = lfsr_adv;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UNSEEDED;
            lfsr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = (state_q == RUN);

endmodule

// File: tb/tb_xor_descrambler.sv
module tb_xor_descrambler;

    localparam logic [31:0] TB_POLY = 32'h04C1_1DB7;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [31:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        locked;
`ifdef XOR_DESCR_BYPASS_EN
    logic        bypass;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_descrambler dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .locked    (locked)
`ifdef XOR_DESCR_BYPASS_EN
        ,
        .bypass    (bypass)
`endif
    );

    // Reference keystream: 32 single Galois steps.
    function automatic logic [31:0] ref_step32(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < 32; k++) begin
            if (r[31]) r = (r << 1) ^ TB_POLY;
            else       r = r << 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ks;          // model of DUT keystream
    logic [31:0] tx_ks;       // scrambler-side keystream
    logic [31:0] held;
    logic [31:0] pt_q[$];
    logic [31:0] pt, exp_w;
    int          sent, rcvd, cyc;
    bit          acc, drn, stall;

    initial begin
        rst       = 1'b1;
        seed_load = 1'b0;
        seed      = '0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        out_ready = 1'b1;
`ifdef XOR_DESCR_BYPASS_EN
        bypass    = 1'b0;
`endif
        #1;
        tick(); tick();
        chk("rst_out_data", out_data, 32'h0);
        rst = 1'b0;
        #1;
        // Unseeded: input offered but never taken.
        chk("unseeded_in_ready", {31'h0, in_ready}, 32'h0);
        chk("unseeded_out_valid", {31'h0, out_valid}, 32'h0);
        chk("unseeded_locked", {31'h0, locked}, 32'h0);
        tick();
        chk("unseeded_out_valid2", {31'h0, out_valid}, 32'h0);
        chk("unseeded_in_ready2", {31'h0, in_ready}, 32'h0);

        // Seed DEADBEEF; in_ready must stay low during the load cycle.
        in_valid  = 1'b0;
        seed_load = 1'b1;
        seed      = 32'hDEAD_BEEF;
        #1;
        chk("seedload_in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        seed_load = 1'b0;
        ks = 32'hDEAD_BEEF;
        chk("locked_after_seed", {31'h0, locked}, 32'h1);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        #1;
        chk("run_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        chk("first_word_valid", {31'h0, out_valid}, 32'h1);
        chk("first_word_data", out_data, 32'h0);
        ks = ref_step32(ks);
        in_data = 32'h0;
        tick();
        chk("second_word_data", out_data, ks);
        ks = ref_step32(ks);
        in_valid = 1'b0;
        tick();
        chk("drained_out_valid", {31'h0, out_valid}, 32'h0);

        // Zero seed substitutes all-ones.
        seed_load = 1'b1;
        seed      = 32'h0;
        tick();
        seed_load = 1'b0;
        ks = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        tick();
        chk("zero_seed_data", out_data, 32'h0);
        ks = ref_step32(ks);
        in_data = 32'h0;
        tick();
        chk("zero_seed_next", out_data, ks);
        ks = ref_step32(ks);
        in_valid = 1'b0;
        tick();

        // Backpressure, then reseed while a word is pending.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_A5A5;
        tick();
        held = 32'hA5A5_A5A5 ^ ks;
        chk("bp_word", out_data, held);
        #1;
        chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        seed_load = 1'b1;
        seed      = 32'h1234_5678;
        tick();
        seed_load = 1'b0;
        ks = 32'h1234_5678;
        chk("reseed_hold_valid", {31'h0, out_valid}, 32'h1);
        chk("reseed_hold_data", out_data, held);
        in_data = 32'h0F0F_0F0F;
        tick();
        chk("bp_hold_data", out_data, held);
        chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        #1;
        chk("drain_accept_ready", {31'h0, in_ready}, 32'h1);
        tick();
        chk("reseed_new_word", out_data, 32'h0F0F_0F0F ^ 32'h1234_5678);
        chk("drain_accept_valid", {31'h0, out_valid}, 32'h1);
        ks = ref_step32(ks);
        in_valid = 1'b0;
        tick();
        chk("post_reseed_drain", {31'h0, out_valid}, 32'h0);

`ifdef XOR_DESCR_BYPASS_EN
        // Bypass passes the word and leaves the keystream where it was.
        in_valid = 1'b1;
        bypass   = 1'b1;
        in_data  = 32'h1234_5678;
        tick();
        chk("bypass_data", out_data, 32'h1234_5678);
        bypass  = 1'b0;
        in_data = 32'h0;
        tick();
        chk("post_bypass_ks", out_data, ks);
        ks = ref_step32(ks);
        in_valid = 1'b0;
        tick();
`endif

        // Random round-trip against a scrambler model.
        seed_load = 1'b1;
        seed      = $urandom();
        tick();
        seed_load = 1'b0;
        tx_ks = (seed == 32'h0) ? 32'hFFFF_FFFF : seed;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        pt   = $urandom();
        stall = 1'b0;
        while ((rcvd < 64) && (cyc < 3000)) begin
            in_valid  = (sent < 64) && ($urandom_range(0, 3) != 0);
            in_data   = pt ^ tx_ks;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall) chk("rt_stall_hold", out_data, held);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn) begin
                if (pt_q.size() == 0) begin
                    chk("rt_duplicate", 32'h1, 32'h0);
                end else begin
                    exp_w = pt_q.pop_front();
                    chk("rt_word", out_data, exp_w);
                end
                rcvd++;
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            if (acc) begin
                pt_q.push_back(pt);
                tx_ks = ref_step32(tx_ks);
                pt = $urandom();
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rt_timeout", {31'h0, cyc >= 3000}, 32'h0);
        chk("rt_sent", sent, 64);
        chk("rt_rcvd", rcvd, 64);
        chk("rt_queue_empty", pt_q.size(), 0);

        // Reset mid-stream drops the pending word and the seed.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5555_AAAA;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midrst_locked", {31'h0, locked}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("midrst_out_data", out_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
